// File: rtl/uart_pkg.sv
// Shared types and constants for the Hamming-encoded UART transmit path.
package uart_pkg;

  localparam int unsigned CODE_W        = 7;
  localparam logic        FRAME_PAD_BIT = 1'b0;
  localparam int unsigned CNT_W         = 8;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ENCODE       = 3'd1,
    WAIT_ENC     = 3'd2,
    LAUNCH       = 3'd3,
    WAIT_BUSY_HI = 3'd4,
    WAIT_BUSY_LO = 3'd5
  } sched_state_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    nxt = idx + 32'd1;
    if (nxt >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic take_s;

  // Offsets are scanned in priority order; once one hits, later offsets are masked.
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {IDX_W{1'b0}};
    grant_vld = 1'b0;
    take_s    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        take_s    = !grant_vld && req_valid[i] && (i == ((32'(ptr) + k) % NUM_REQ));
        grant[i]  = grant[i] | take_s;
        grant_idx = take_s ? IDX_W'(i) : grant_idx;
        grant_vld = grant_vld | take_s;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one Hamming(7,4) encoder and one UART transmitter among NUM_REQ nibble
// sources, one frame at a time, with round-robin fairness and stall timeouts.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 enc_ena,
  output logic [3:0]           enc_data,
  input  logic [CODE_W-1:0]    enc_code,
  input  logic                 enc_valid,
  output logic                 uart_start,
  output logic [7:0]           uart_data,
  input  logic                 uart_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic [7:0]           frames_sent,
  output logic                 err_timeout,
  input  logic                 err_clr
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_t       state_r, next_state_s;
  logic [ID_W-1:0]    ptr_r, grant_id_r, arb_idx_s;
  logic [NUM_REQ-1:0] arb_grant_s;
  logic               arb_vld_s;
  logic [3:0]         win_nibble_s, enc_data_r;
  logic [7:0]         uart_data_r, frames_r;
  logic [CNT_W-1:0]   tmo_cnt_r;
  logic               tmo_hit_s, timeout_s, done_s, ret_idle_s;
  logic               enc_ena_r, uart_start_r, active_r, err_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .grant_vld (arb_vld_s)
  );

  // Ready is gated by rst so the reset state is visible even while sources are requesting.
  assign req_ready = (state_r == IDLE && !rst) ? arb_grant_s : {NUM_REQ{1'b0}};

  // One-hot grant selects the winning nibble without a variable part-select.
  always_comb begin
    win_nibble_s = 4'h0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      win_nibble_s = win_nibble_s | (req_data[4*i +: 4] & {4{arb_grant_s[i]}});
    end
  end

  assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
  assign ret_idle_s = (state_r != IDLE) && (next_state_s == IDLE);

  // Next-state logic plus the timeout and frame-complete events.
  always_comb begin
    next_state_s = state_r;
    timeout_s    = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_vld_s) begin
          next_state_s = ENCODE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ENCODE: next_state_s = WAIT_ENC;
      WAIT_ENC: begin
        if (enc_valid) begin
          next_state_s = LAUNCH;
        end else if (tmo_hit_s) begin
          next_state_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = WAIT_ENC;
        end
      end
      LAUNCH: next_state_s = WAIT_BUSY_HI;
      WAIT_BUSY_HI: begin
        if (uart_busy) begin
          next_state_s = WAIT_BUSY_LO;
        end else if (tmo_hit_s) begin
          next_state_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = WAIT_BUSY_HI;
        end
      end
      WAIT_BUSY_LO: begin
        if (!uart_busy) begin
          next_state_s = IDLE;
          done_s       = 1'b1;
        end else begin
          next_state_s = WAIT_BUSY_LO;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register and the pulse/level outputs, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      enc_ena_r    <= 1'b0;
      uart_start_r <= 1'b0;
      active_r     <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      enc_ena_r    <= (next_state_s == ENCODE);
      uart_start_r <= (next_state_s == LAUNCH);
      active_r     <= (next_state_s != IDLE);
    end
  end

  // Grant bookkeeping and the data held toward encoder and transmitter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id_r  <= {ID_W{1'b0}};
      ptr_r       <= {ID_W{1'b0}};
      enc_data_r  <= 4'h0;
      uart_data_r <= 8'h00;
    end else begin
      if (state_r == IDLE && arb_vld_s) begin
        grant_id_r <= arb_idx_s;
        enc_data_r <= win_nibble_s;
      end
      if (state_r == WAIT_ENC && enc_valid) begin
        uart_data_r <= {FRAME_PAD_BIT, enc_code};
      end
      if (ret_idle_s) begin
        ptr_r <= ID_W'(wrap_inc(32'(grant_id_r), NUM_REQ));
      end
    end
  end

  // Stall counter, completed-frame counter and sticky timeout flag (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
      frames_r  <= 8'h00;
      err_r     <= 1'b0;
    end else begin
      if (state_r == ENCODE || state_r == LAUNCH) begin
        tmo_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == WAIT_ENC && !enc_valid) ||
                   (state_r == WAIT_BUSY_HI && !uart_busy)) begin
        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end
      if (done_s) begin
        frames_r <= frames_r + 8'd1;
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end
    end
  end

  assign enc_ena     = enc_ena_r;
  assign enc_data    = enc_data_r;
  assign uart_start  = uart_start_r;
  assign uart_data   = uart_data_r;
  assign grant_id    = grant_id_r;
  assign active      = active_r;
  assign frames_sent = frames_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with encoder/transmitter stubs driven on negedge.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        enc_ena;
  logic [3:0]  enc_data;
  logic [6:0]  enc_code;
  logic        enc_valid;
  logic        uart_start;
  logic [7:0]  uart_data;
  logic        uart_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic [7:0]  frames_sent;
  logic        err_timeout;
  logic        err_clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic enc_mute = 1'b0;
  logic tx_mute  = 1'b0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enc_ena(enc_ena), .enc_data(enc_data),
    .enc_code(enc_code), .enc_valid(enc_valid), .uart_start(uart_start),
    .uart_data(uart_data), .uart_busy(uart_busy), .grant_id(grant_id),
    .active(active), .frames_sent(frames_sent), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] data;
    logic [1:0]  id;
    logic [3:0]  nib;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [6:0] ham74(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Encoder answers one cycle after enc_ena; transmitter is busy 3 cycles, rising one cycle after start.
  logic       enc_pend = 1'b0;
  logic [3:0] pend_nib = 4'h0;
  logic       tx_pend  = 1'b0;
  int         busy_left = 0;
  initial begin
    enc_valid = 1'b0;
    enc_code  = 7'h00;
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      enc_valid = 1'b0;
      if (enc_pend) begin
        enc_valid = 1'b1;
        enc_code  = ham74(pend_nib);
        enc_pend  = 1'b0;
      end
      if (enc_ena === 1'b1 && !enc_mute) begin
        enc_pend = 1'b1;
        pend_nib = enc_data;
      end
      if (uart_busy) begin
        if (busy_left <= 1) begin
          uart_busy = 1'b0;
          busy_left = 0;
        end else begin
          busy_left--;
        end
      end else if (tx_pend) begin
        uart_busy = 1'b1;
        busy_left = 3;
        tx_pend   = 1'b0;
      end
      if (uart_start === 1'b1 && !tx_mute) tx_pend = 1'b1;
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (active !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, active, 32'd0);
  endtask

  task automatic wait_start(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (uart_start !== 1'b1 && n < 40);
    chk(name, uart_start, 32'd1);
  endtask

  task automatic wait_enc(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (enc_ena !== 1'b1 && n < 40);
    chk(name, enc_ena, 32'd1);
  endtask

  task automatic run_frame(input vec_t v, input logic [7:0] exp_frames);
    int n;
    @(negedge clk);
    req_valid = v.valid;
    req_data  = v.data;
    #1;
    chk("ready_onehot", req_ready, 32'd1 << v.id);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("enc_ena", enc_ena, 32'd1);
    chk("ready_low", req_ready, 32'd0);
    chk("grant_id", grant_id, v.id);
    chk("enc_data", enc_data, v.nib);
    chk("active", active, 32'd1);
    @(negedge clk);
    chk("enc_ena_pulse", enc_ena, 32'd0);
    wait_start("uart_start", n);
    chk("start_latency", n, 32'd1);
    chk("uart_data", uart_data, {1'b0, ham74(v.nib)});
    @(negedge clk);
    chk("uart_start_pulse", uart_start, 32'd0);
    wait_idle("frame_done");
    chk("frames_sent", frames_sent, exp_frames);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int  n;
    logic err_seen;
    req_valid = 4'b0000;
    req_data  = 16'h0000;
    err_clr   = 1'b0;
    vecs[0] = '{4'b0100, 16'h0B00, 2'd2, 4'hB};
    vecs[1] = '{4'b0011, 16'h0021, 2'd0, 4'h1};
    vecs[2] = '{4'b1001, 16'h7005, 2'd3, 4'h7};
    vecs[3] = '{4'b1111, 16'hEDCA, 2'd0, 4'hA};
    vecs[4] = '{4'b1100, 16'hF300, 2'd2, 4'h3};
    vecs[5] = '{4'b0110, 16'h0900, 2'd1, 4'h0};
    vecs[6] = '{4'b1000, 16'h6000, 2'd3, 4'h6};

    // Reset values, with requests pending to show ready is held low.
    repeat (3) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", req_ready, 32'd0);
    chk("rst_enc_ena", enc_ena, 32'd0);
    chk("rst_enc_data", enc_data, 32'd0);
    chk("rst_uart_start", uart_start, 32'd0);
    chk("rst_uart_data", uart_data, 32'd0);
    chk("rst_grant_id", grant_id, 32'd0);
    chk("rst_active", active, 32'd0);
    chk("rst_frames", frames_sent, 32'd0);
    chk("rst_err", err_timeout, 32'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_no_req_ready", req_ready, 32'd0);

    // All sources continuously valid: grants rotate 0,1,2,3,0.
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      wait_enc("rr_enc");
      chk("rr_grant", grant_id, 32'(k % 4));
      chk("rr_nibble", enc_data, 32'(k % 4 + 1));
      wait_idle("rr_done");
      if (k == 4) req_valid = 4'b0000;
    end
    chk("rr_frames", frames_sent, 32'd5);

    for (int i = 0; i < 7; i++) run_frame(vecs[i], 8'(6 + i));

    // Encoder never answers: timeout 8 cycles after WAIT_ENC entry.
    enc_mute = 1'b1;
    @(negedge clk);
    req_valid = 4'b0010;
    req_data  = 16'h00C0;
    @(negedge clk);
    req_valid = 4'b0000;
    chk("enc_tmo_grant", grant_id, 32'd1);
    repeat (8) @(negedge clk);
    chk("enc_tmo_early_err", err_timeout, 32'd0);
    chk("enc_tmo_early_active", active, 32'd1);
    @(negedge clk);
    chk("enc_tmo_err", err_timeout, 32'd1);
    chk("enc_tmo_idle", active, 32'd0);
    chk("enc_tmo_frames", frames_sent, 32'd12);
    enc_mute = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", err_timeout, 32'd0);
    run_frame('{4'b0011, 16'h0085, 2'd0, 4'h5}, 8'd13);

    // Transmitter never goes busy; err_clr held so set must win.
    tx_mute = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    req_valid = 4'b0100;
    req_data  = 16'h0A00;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (10) @(negedge clk);
    chk("tx_tmo_early_err", err_timeout, 32'd0);
    chk("tx_tmo_early_active", active, 32'd1);
    @(negedge clk);
    chk("tx_tmo_set_wins", err_timeout, 32'd1);
    chk("tx_tmo_idle", active, 32'd0);
    err_clr = 1'b0;
    tx_mute = 1'b0;
    @(negedge clk);
    chk("err_sticky", err_timeout, 32'd1);
    chk("tx_tmo_frames", frames_sent, 32'd13);
    run_frame('{4'b0010, 16'h0030, 2'd1, 4'h3}, 8'd14);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr2", err_timeout, 32'd0);

    // Reset during WAIT_BUSY_LO.
    @(negedge clk);
    req_valid = 4'b0100;
    req_data  = 16'h0E00;
    @(negedge clk);
    req_valid = 4'b0000;
    chk("mid_grant", grant_id, 32'd2);
    wait_start("mid_start", n);
    repeat (2) @(negedge clk);
    chk("mid_in_lo", active, 32'd1);
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 32'd0);
    chk("mid_rst_uart_data", uart_data, 32'd0);
    chk("mid_rst_enc_data", enc_data, 32'd0);
    chk("mid_rst_grant", grant_id, 32'd0);
    chk("mid_rst_active", active, 32'd0);
    chk("mid_rst_frames", frames_sent, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 32'd1);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("post_rst_enc", enc_ena, 32'd1);
    chk("post_rst_grant", grant_id, 32'd0);
    chk("post_rst_nibble", enc_data, 32'd1);
    wait_idle("post_rst_done");
    chk("post_rst_frames", frames_sent, 32'd1);

    // 256 frames from reset: counter wraps, no timeouts.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_seen = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      req_data  = 16'h0009;
      @(negedge clk);
      req_valid = 4'b0000;
      wait_idle("wrap_done");
      err_seen = err_seen | err_timeout;
      if (i == 255) chk("wrap_255", frames_sent, 32'd255);
    end
    chk("wrap_0", frames_sent, 32'd0);
    chk("wrap_no_err", err_seen, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
